flt_cfg_seq: RTL and testbench
==============================

// Module: flt_cfg_seq
// PURPOSE
//  Coefficient-load sequencer in front of the FLT filter block. Takes a load command plus a
//  valid/ready coefficient stream and drives FLT's WrEn/Addr/PAR port. Mutes the sample path
//  during a reload, then flushes the filter pipeline with zeros. Sits between the host config
//  bus and FLT; the audio sample path passes through it.
// PARAMETERS
//  ADDR_WIDTH   5   FLT parameter address bits (max 2^ADDR_WIDTH = 32 words)
//  MEM_WIDTH    32  coefficient word width
//  IN_WIDTH     24  sample width
//  FLUSH_CYC    32  zero-sample cycles issued after a load
//  TIMEOUT_CYC  64  max idle cycles waiting for Cof_Valid_SI during LOAD
// PORTS
//  Clk_CI       in   1             single clock, rising edge
//  Rst_RI       in   1             synchronous, active-high reset
//  Start_SI     in   1             1-cycle load request
//  NumCoef_DI   in   ADDR_WIDTH+1  words to load, sampled with Start_SI
//  Cof_Valid_SI in   1             coefficient word valid
//  Cof_Data_DI  in   MEM_WIDTH     coefficient word
//  Cof_Ready_SO out  1             sequencer accepts a word
//  Smp_In_DI    in   IN_WIDTH      live sample from upstream
//  WrEn_SO      out  1             to FLT WrEn_SI
//  Addr_DO      out  ADDR_WIDTH    to FLT Addr_DI
//  PAR_Out_DO   out  MEM_WIDTH     to FLT PAR_In_DI
//  FLT_In_DO    out  IN_WIDTH      to FLT sta_FLT_In_DI
//  Busy_SO      out  1             high in any state other than IDLE
//  Done_SO      out  1             1-cycle pulse on successful completion
//  Err_SO       out  1             sticky error, cleared by the next accepted Start_SI
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0. Reset is honoured in any
//    state: a reset mid-LOAD drops WrEn_SO the next cycle and leaves partial FLT contents.
//  - FSM states:
//    - IDLE: FLT_In_DO = Smp_In_DI, delayed 1 cycle. Start_SI with NumCoef in 1..2^ADDR_WIDTH
//      -> LOAD, clear Err, idx = 0. Start_SI with NumCoef = 0 or > 2^ADDR_WIDTH -> ERR; no
//      writes are issued.
//    - LOAD: Cof_Ready_SO = 1 while idx < NumCoef.
//      - Each transfer (Valid & Ready) drives, on the following cycle, WrEn_SO = 1,
//        Addr_DO = idx, PAR_Out_DO = Cof_Data_DI; then idx increments.
//      - After the last transfer, Cof_Ready_SO drops in the same cycle as that last WrEn_SO.
//        The state then goes -> FLUSH, or -> CHK when the checksum feature is compiled in.
//      - FLT_In_DO is held at 0 throughout LOAD.
//      - The idle counter resets on every transfer. When it reaches TIMEOUT_CYC -> ERR.
//    - FLUSH: FLT_In_DO = 0 for exactly FLUSH_CYC cycles -> DONE.
//    - DONE: Done_SO = 1 for one cycle -> IDLE.
//    - ERR: Err_SO set, Cof_Ready_SO = 0, FLT_In_DO = 0 for 1 cycle -> IDLE. Err_SO stays high.
//  - Start_SI outside IDLE is ignored; there is no queueing.
//  - Cof_Valid_SI in IDLE is ignored (Ready = 0).
//  - idx wraps never: the count is bounded by NumCoef.
//  - Write latency: transfer at cycle N -> FLT write at N+1.
//  - Total latency, Start to Done: NumCoef transfers + 1 + FLUSH_CYC + 1 cycles, minimum.
// CONFIGURATION
//  FLT_CFG_CHKSUM_EN defined:
//    - After the last coefficient, the sequencer enters CHK and accepts one extra word.
//    - Match: mod-2^MEM_WIDTH sum of all loaded words == that word -> FLUSH.
//    - Mismatch -> ERR. Coefficients are already written; the filter stays muted only for the
//      ERR cycle.
//    - The timeout also applies in CHK.
//  FLT_CFG_CHKSUM_EN undefined: no CHK state, no extra word, no checksum adder.
// STRUCTURE
//  - flt_pkg holds:
//    - width localparams: ADDR_WIDTH, MEM_WIDTH, IN_WIDTH
//    - FSM state enum: IDLE, LOAD, CHK, FLUSH, DONE, ERR
//    - the NumCoef range check
//  - Sub-module flt_cfg_cnt is a loadable down-counter with zero flag. It is instantiated twice:
//    - LOAD idle timeout
//    - FLUSH length
// TESTING
//  - Load 32 words 0..31, Valid held high:
//    - 32 consecutive WrEn_SO with Addr 0..31, data matching
//    - Done_SO at Start + 32 + 1 + 32 + 1 cycles
//    - FLT_In_DO = 0 from LOAD entry until DONE
//  - Load 4 words with Valid toggling 1/0: 4 writes only, on the cycle after each transfer.
//    Idle gaps below TIMEOUT_CYC cause no error.
//  - NumCoef = 0, and separately NumCoef = 33: Err_SO = 1 next cycle, no WrEn_SO, Busy_SO one
//    cycle. A following valid Start clears Err_SO.
//  - Load 8 words, stop Valid after word 3 for 64 cycles: ERR with Err_SO = 1, only Addr 0..2
//    written, no Done_SO.
//  - Start_SI pulsed mid-LOAD is ignored. Rst_RI at word 5 of 16: all outputs 0 next cycle,
//    state IDLE.
//  - FLT_CFG_CHKSUM_EN, words 1,2,3 then 6 -> Done_SO. Words 1,2,3 then 7 -> Err_SO, no Done_SO.

Source files
------------

// File: rtl/flt_pkg.sv
// flt_pkg: shared widths, FSM states and NumCoef range check for the FLT config sequencer
package flt_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int MEM_WIDTH = 32;
    localparam int IN_WIDTH = 24;
    typedef enum logic [2:0] {IDLE, LOAD, CHK, FLUSH, DONE, ERR} state_e;
    function automatic logic num_ok(input logic [ADDR_WIDTH:0] n);
        return n != '0 && n <= {1'b1, {ADDR_WIDTH{1'b0}}};
    endfunction
endpackage

// File: rtl/flt_cfg_cnt.sv
// flt_cfg_cnt: loadable down-counter that saturates at zero and flags it
module flt_cfg_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    assign zero = cnt_q == '0;
    always_comb cnt_d = ld ? ld_val : zero ? cnt_q : cnt_q - W'(1);
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/flt_cfg_seq.sv
// flt_cfg_seq: FLT coefficient-load sequencer with sample mute and flush; FLT_CFG_CHKSUM_EN adds a trailing checksum word
module flt_cfg_seq
    import flt_pkg::*;
#(
    parameter int FLUSH_CYC   = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Start_SI,
    input  logic [ADDR_WIDTH:0]   NumCoef_DI,
    input  logic                  Cof_Valid_SI,
    input  logic [MEM_WIDTH-1:0]  Cof_Data_DI,
    output logic                  Cof_Ready_SO,
    input  logic [IN_WIDTH-1:0]   Smp_In_DI,
    output logic                  WrEn_SO,
    output logic [ADDR_WIDTH-1:0] Addr_DO,
    output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
    output logic [IN_WIDTH-1:0]   FLT_In_DO,
    output logic                  Busy_SO,
    output logic                  Done_SO,
    output logic                  Err_SO
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    state_e state_q, state_d;
    logic [ADDR_WIDTH:0] idx_q, idx_d, num_q, num_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0] par_q, par_d;
    logic [IN_WIDTH-1:0] flt_in_q, flt_in_d;
    logic ready_q, ready_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic fire, all_in, to_ld, to_zero, fl_zero, chk_ok;
    assign fire = Cof_Valid_SI & ready_q;
    assign all_in = idx_q == num_q;
    // The idle timer rearms on every transfer and whenever the stream is not being waited on.
    assign to_ld = fire | (state_q == LOAD ? all_in : state_q != CHK);
    flt_cfg_cnt #(.W(TW)) u_timeout (
        .clk(Clk_CI), .rst(Rst_RI), .ld(to_ld), .ld_val(TW'(TIMEOUT_CYC - 1)), .zero(to_zero)
    );
    flt_cfg_cnt #(.W(FW)) u_flush (
        .clk(Clk_CI), .rst(Rst_RI), .ld(state_q != FLUSH), .ld_val(FW'(FLUSH_CYC - 1)), .zero(fl_zero)
    );
`ifdef FLT_CFG_CHKSUM_EN
    localparam state_e LOAD_NEXT = CHK;
    logic [MEM_WIDTH-1:0] sum_q, sum_d;
    assign sum_d = state_q == IDLE ? '0 : (fire && state_q == LOAD) ? sum_q + Cof_Data_DI : sum_q;
    assign chk_ok = sum_q == Cof_Data_DI;
    always_ff @(posedge Clk_CI) sum_q <= Rst_RI ? '0 : sum_d;
`else
    localparam state_e LOAD_NEXT = FLUSH;
    assign chk_ok = 1'b1;
`endif
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            num_q    <= '0;
            ready_q  <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            par_q    <= '0;
            flt_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            ready_q  <= ready_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            par_q    <= par_d;
            flt_in_q <= flt_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start_SI) state_d = num_ok(NumCoef_DI) ? LOAD : ERR;
            LOAD:    if (all_in) state_d = LOAD_NEXT; else if (!fire && to_zero) state_d = ERR;
            CHK:     if (fire) state_d = chk_ok ? FLUSH : ERR; else if (to_zero) state_d = ERR;
            FLUSH:   if (fl_zero) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        num_d    = (state_q == IDLE && Start_SI) ? NumCoef_DI : num_q;
        idx_d    = state_q == IDLE ? '0 : idx_q + (ADDR_WIDTH + 1)'(fire && state_q == LOAD);
        ready_d  = state_d == CHK || (state_d == LOAD && idx_d != num_d);
        wr_d     = fire && state_q == LOAD;
        addr_d   = idx_q[ADDR_WIDTH-1:0];
        par_d    = Cof_Data_DI;
        flt_in_d = state_d == IDLE ? Smp_In_DI : '0;
        busy_d   = state_d != IDLE;
        done_d   = state_d == DONE;
        err_d    = state_d == ERR || (err_q && !(state_q == IDLE && state_d == LOAD));
    end
    assign Cof_Ready_SO = ready_q;
    assign WrEn_SO      = wr_q;
    assign Addr_DO      = addr_q;
    assign PAR_Out_DO   = par_q;
    assign FLT_In_DO    = flt_in_q;
    assign Busy_SO      = busy_q;
    assign Done_SO      = done_q;
    assign Err_SO       = err_q;
endmodule

// File: tb/tb_flt_cfg_seq.sv
// tb_flt_cfg_seq: randomized and directed checks of flt_cfg_seq against a cycle-list reference model
module tb_flt_cfg_seq;
    import flt_pkg::*;
    localparam int FLUSH = 32, TMO = 64, MAXC = 2048, NMAX = 1 << ADDR_WIDTH;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, vld_in = 1'b0;
    logic [ADDR_WIDTH:0] num_in = '0;
    logic [MEM_WIDTH-1:0] dat_in = '0;
    logic [IN_WIDTH-1:0] smp = '0;
    logic rdy, wr, busy, done, err;
    logic [ADDR_WIDTH-1:0] addr;
    logic [MEM_WIDTH-1:0] par;
    logic [IN_WIDTH-1:0] flt_in;
    int total = 0, bad = 0;
    bit vld[MAXC], st[MAXC];
    logic [MEM_WIDTH-1:0] dat[MAXC];
    bit e_wr[MAXC], e_rdy[MAXC], e_busy[MAXC], e_done[MAXC];
    int e_addr[MAXC];
    logic [MEM_WIDTH-1:0] e_dat[MAXC];
    int err_t, done_t, end_t, seen_done;

    flt_cfg_seq dut (
        .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .NumCoef_DI(num_in),
        .Cof_Valid_SI(vld_in), .Cof_Data_DI(dat_in), .Cof_Ready_SO(rdy), .Smp_In_DI(smp),
        .WrEn_SO(wr), .Addr_DO(addr), .PAR_Out_DO(par), .FLT_In_DO(flt_in),
        .Busy_SO(busy), .Done_SO(done), .Err_SO(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int t = 0; t < MAXC; t++) begin
            vld[t] = 1'b0;
            st[t] = 1'b0;
            dat[t] = $urandom;
        end
    endtask

    // Stream-level model: the first NumCoef valid cycles after Start are transfers, each
    // written one cycle later; TMO consecutive idle cycles abort; completion costs 2+FLUSH.
    task automatic model(input int num);
        int k = 0, idle = 0, last = 0;
        for (int t = 0; t < MAXC; t++) begin
            e_wr[t] = 1'b0; e_rdy[t] = 1'b0; e_busy[t] = 1'b0; e_done[t] = 1'b0;
        end
        err_t = 0;
        done_t = 0;
        if (num < 1 || num > NMAX) err_t = 1;
        else for (int t = 1; t < MAXC - FLUSH - 4; t++) begin
            if (k == num) begin
                done_t = last + 2 + FLUSH;
                break;
            end
            e_rdy[t] = 1'b1;
            if (vld[t]) begin
                e_wr[t+1] = 1'b1; e_addr[t+1] = k; e_dat[t+1] = dat[t];
                k++; idle = 0; last = t;
            end else begin
                idle++;
                if (idle == TMO) begin
                    err_t = t + 1;
                    break;
                end
            end
        end
        end_t = err_t != 0 ? err_t : done_t;
        for (int t = 1; t <= end_t; t++) e_busy[t] = 1'b1;
        if (done_t != 0) e_done[done_t] = 1'b1;
    endtask

    task automatic run(input int num, input string name);
        model(num);
        seen_done = 0;
        for (int t = 0; t < end_t + 3; t++) begin
            start = (t == 0) || st[t];
            num_in = (t == 0) ? (ADDR_WIDTH + 1)'(num) : (ADDR_WIDTH + 1)'(3);
            vld_in = vld[t];
            dat_in = dat[t];
            smp = IN_WIDTH'($urandom);
            @(negedge clk);
            if (done && seen_done == 0) seen_done = t + 1;
            check({name, ".wr"}, wr, e_wr[t+1]);
            if (e_wr[t+1]) begin
                check({name, ".addr"}, addr, e_addr[t+1]);
                check({name, ".par"}, par, e_dat[t+1]);
            end
            check({name, ".rdy"}, rdy, e_rdy[t+1]);
            check({name, ".busy"}, busy, e_busy[t+1]);
            check({name, ".done"}, done, e_done[t+1]);
            check({name, ".err"}, err, err_t != 0 && t + 1 >= err_t);
            if (t + 1 <= end_t) check({name, ".mute"}, flt_in, 0);
        end
        start = 1'b0;
        vld_in = 1'b0;
    endtask

`ifdef FLT_CFG_CHKSUM_EN
    task automatic run_chk(input logic [MEM_WIDTH-1:0] word, input bit ok);
        int nd = 0, nw = 0;
        for (int t = 0; t < 50; t++) begin
            start = t == 0;
            num_in = (ADDR_WIDTH + 1)'(3);
            vld_in = t >= 1;
            dat_in = t <= 3 ? MEM_WIDTH'(t) : word;
            @(negedge clk);
            nd += int'(done);
            nw += int'(wr);
        end
        vld_in = 1'b0;
        check("chk.done", nd, ok);
        check("chk.err", err, !ok);
        check("chk.writes", nw, 3);
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.wr", wr, 0);
        check("rst.err", err, 0);
        check("rst.flt_in", flt_in, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [IN_WIDTH-1:0] s;
            s = IN_WIDTH'($urandom);
            smp = s;
            vld_in = 1'b1;
            @(negedge clk);
            check("idle.pass", flt_in, s);
            check("idle.rdy", rdy, 0);
            check("idle.wr", wr, 0);
        end
        vld_in = 1'b0;
        clear_stim();
        run(0, "num0");
        clear_stim();
        run(NMAX + 1, "num33");
`ifdef FLT_CFG_CHKSUM_EN
        run_chk(6, 1'b1);
        run_chk(7, 1'b0);
        run_chk(6, 1'b1);
`else
        clear_stim();
        for (int t = 1; t < MAXC; t++) begin
            vld[t] = 1'b1;
            dat[t] = MEM_WIDTH'(t - 1);
        end
        st[10] = 1'b1;
        run(NMAX, "full");
        check("full.done_at", seen_done, 66);
        clear_stim();
        for (int t = 1; t < MAXC; t++) vld[t] = t[0];
        run(4, "toggle");
        clear_stim();
        for (int t = 1; t <= 3; t++) vld[t] = 1'b1;
        run(8, "timeout");
        clear_stim();
        for (int t = 1; t < MAXC; t++) vld[t] = t <= 2 || t >= 66;
        run(4, "gap63");
        for (int n = 0; n < 6; n++) begin
            int gap = 0;
            clear_stim();
            for (int t = 1; t < MAXC; t++) begin
                if (gap > 0) gap--;
                else if ($urandom_range(0, 15) == 0) gap = $urandom_range(1, 70);
                else vld[t] = $urandom_range(0, 1) == 1;
            end
            run($urandom_range(1, NMAX), "rand");
        end
`endif
        clear_stim();
        for (int t = 0; t < 6; t++) begin
            start = t == 0;
            num_in = (ADDR_WIDTH + 1)'(16);
            vld_in = t >= 1;
            dat_in = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst.wr", wr, 0);
        check("mid_rst.rdy", rdy, 0);
        check("mid_rst.busy", busy, 0);
        check("mid_rst.addr", addr, 0);
        check("mid_rst.par", par, 0);
        check("mid_rst.flt_in", flt_in, 0);
        check("mid_rst.err", err, 0);
        rst = 1'b0;
        smp = 24'h5a5a5a;
        @(negedge clk);
        check("post_rst.busy", busy, 0);
        check("post_rst.rdy", rdy, 0);
        check("post_rst.wr", wr, 0);
        check("post_rst.pass", flt_in, 24'h5a5a5a);
        vld_in = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
